// File: rtl/morph_open_sched.sv
// Morphological opening scheduler: runs a 3x3 erode pass (bank 0 -> bank 1), then a 3x3 dilate
// pass (bank 1 -> bank 0). It drives the frame RAM strobes, the core valid/clear and the pipeline flush.
module morph_open_sched #(
   parameter int PIC_WIDTH  = 250,
   parameter int PIC_HEIGHT = 250,
   parameter int ADDR_W     = 16,
   parameter int CORE_LAT   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic              pass_sel,
   output logic              core_valid,
   output logic              core_rst_n,
   output logic              mem_rd_en,
   output logic              mem_rd_bank,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              mem_wr_en,
   output logic              mem_wr_bank,
   output logic [ADDR_W-1:0] mem_wr_addr
);

   localparam int N  = PIC_WIDTH * PIC_HEIGHT;
   localparam int CW = ADDR_W + 1;

   localparam logic [CW-1:0]     N_C     = CW'(N);
   localparam logic [CW-1:0]     TOTAL_C = CW'(N + CORE_LAT);
   localparam logic [CW-1:0]     LAST_C  = CW'(N + CORE_LAT - 1);
   localparam logic [CW-1:0]     LAT_C   = CW'(CORE_LAT);
   localparam logic [CW-1:0]     ONE_C   = CW'(1);
   localparam logic [ADDR_W-1:0] LAT_A   = ADDR_W'(CORE_LAT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR_E,
      S_ERODE,
      S_CLR_D,
      S_DILATE,
      S_DONE
   } state_e;

   state_e        state_q;
   logic [CW-1:0] issue_q;
   logic [CW-1:0] beat_q;
   logic          pend_q;

   logic busy_q;
   logic done_q;
   logic pass_sel_q;
   logic core_rst_n_q;
   logic rd_bank_q;
   logic wr_bank_q;

   logic in_pass;
   logic run;
   logic issue;
   logic beat;
   logic last_beat;
   logic rd_window;
   logic wr_window;

   // hold is a same-cycle freeze, so the three strobes are gated combinationally from the
   // registered engine state; everything else leaves the block straight from a flop.
   assign in_pass   = (state_q == S_ERODE) || (state_q == S_DILATE);
   assign run       = in_pass && !hold;
   assign issue     = run && (issue_q < TOTAL_C);
   assign beat      = run && pend_q;
   assign last_beat = beat && (beat_q == LAST_C);
   assign rd_window = issue_q < N_C;
   assign wr_window = (beat_q >= LAT_C) && (beat_q < TOTAL_C);

   assign mem_rd_en   = issue && rd_window;
   assign mem_rd_addr = rd_window ? issue_q[ADDR_W-1:0] : '0;
   assign core_valid  = beat;
   assign mem_wr_en   = beat && (beat_q >= LAT_C);
   assign mem_wr_addr = wr_window ? (beat_q[ADDR_W-1:0] - LAT_A) : '0;

   assign busy        = busy_q;
   assign done        = done_q;
   assign pass_sel    = pass_sel_q;
   assign core_rst_n  = core_rst_n_q;
   assign mem_rd_bank = rd_bank_q;
   assign mem_wr_bank = wr_bank_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         issue_q      <= '0;
         beat_q       <= '0;
         pend_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_sel_q   <= 1'b0;
         core_rst_n_q <= 1'b1;
         rd_bank_q    <= 1'b0;
         wr_bank_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only here, so every branch below sees this cycle's
         // state and the defaults on the next two lines are simply overridden where needed.
         done_q       <= 1'b0;
         core_rst_n_q <= 1'b1;

         // A pending issue becomes the next run cycle's beat, however long hold lasts in between.
         if ((state_q == S_CLR_E) || (state_q == S_CLR_D)) begin
            issue_q <= '0;
            beat_q  <= '0;
            pend_q  <= 1'b0;
         end else if (run) begin
            if (issue) issue_q <= issue_q + ONE_C;
            if (beat)  beat_q  <= beat_q + ONE_C;
            pend_q <= issue;
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q      <= S_CLR_E;
                  busy_q       <= 1'b1;
                  core_rst_n_q <= 1'b0;
                  pass_sel_q   <= 1'b0;
                  rd_bank_q    <= 1'b0;
                  wr_bank_q    <= 1'b1;
               end
            end
            S_CLR_E: state_q <= S_ERODE;
            S_ERODE: begin
               if (last_beat) begin
                  state_q      <= S_CLR_D;
                  core_rst_n_q <= 1'b0;
                  pass_sel_q   <= 1'b1;
                  rd_bank_q    <= 1'b1;
                  wr_bank_q    <= 1'b0;
               end
            end
            S_CLR_D: state_q <= S_DILATE;
            S_DILATE: begin
               if (last_beat) begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  pass_sel_q <= 1'b0;
                  rd_bank_q  <= 1'b0;
                  wr_bank_q  <= 1'b0;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morph_open_sched.sv
// Scoreboard bench for morph_open_sched on a 4x3 frame: stimulus queues the expected RAM traffic
// and done latency per accepted start, and a negedge monitor pops and compares as the DUT emits them.
module tb_morph_open_sched;

   localparam int W   = 4;
   localparam int H   = 3;
   localparam int AW  = 4;
   localparam int LAT = 3;
   localparam int N   = W * H;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          hold = 1'b0;
   logic          busy, done, pass_sel, core_valid, core_rst_n;
   logic          mem_rd_en, mem_rd_bank, mem_wr_en, mem_wr_bank;
   logic [AW-1:0] mem_rd_addr, mem_wr_addr;

   morph_open_sched #(
      .PIC_WIDTH (W),
      .PIC_HEIGHT(H),
      .ADDR_W    (AW),
      .CORE_LAT  (LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .hold       (hold),
      .busy       (busy),
      .done       (done),
      .pass_sel   (pass_sel),
      .core_valid (core_valid),
      .core_rst_n (core_rst_n),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_bank(mem_rd_bank),
      .mem_rd_addr(mem_rd_addr),
      .mem_wr_en  (mem_wr_en),
      .mem_wr_bank(mem_wr_bank),
      .mem_wr_addr(mem_wr_addr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          bank;
      logic [AW-1:0] addr;
   } rd_t;

   typedef struct packed {
      logic          sel;
      logic          bank;
      logic [AW-1:0] addr;
   } wr_t;

   rd_t rd_q[$];
   wr_t wr_q[$];
   int  lat_q[$];

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: DUT output with no queued expectation at %0t", nm, $time);
   endtask

   // Monitor: cycle 0 is the first cycle busy is high (CLR_E).
   int   cyc = 0;
   int   t0 = 0;
   int   beat_idx = 0;
   int   clr_cnt = 0;
   int   done_cnt = 0;
   logic busy_prev = 1'b0;
   logic done_prev = 1'b0;

   initial begin
      rd_t re;
      wr_t we;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            beat_idx  = 0;
            clr_cnt   = 0;
            busy_prev = 1'b0;
            done_prev = 1'b0;
         end else begin
            if (busy && !busy_prev) t0 = cyc;
            if (done_prev) check("busy_fall", 32'(busy), 32'd0);
            if (hold) check("hold_quiet", 32'({mem_rd_en, mem_wr_en, core_valid}), 32'd0);
            if (!core_rst_n) begin
               check("clr_beats", 32'(beat_idx), 32'((clr_cnt == 0) ? 0 : N + LAT));
               clr_cnt++;
               beat_idx = 0;
            end
            if (mem_rd_en) begin
               if (rd_q.size() == 0) fail("rd_unexpected");
               else begin
                  re = rd_q.pop_front();
                  check("rd_bank_addr", 32'({mem_rd_bank, mem_rd_addr}), 32'(re));
               end
            end
            if (core_valid) begin
               check("wr_align", 32'(mem_wr_en), 32'(beat_idx >= LAT));
               beat_idx++;
            end else if (mem_wr_en) begin
               fail("wr_without_valid");
            end
            if (mem_wr_en) begin
               if (wr_q.size() == 0) fail("wr_unexpected");
               else begin
                  we = wr_q.pop_front();
                  check("wr_sel_bank_addr", 32'({pass_sel, mem_wr_bank, mem_wr_addr}), 32'(we));
               end
            end
            if (done) begin
               check("done_busy", 32'(busy), 32'd1);
               check("done_beats", 32'(beat_idx), 32'(N + LAT));
               check("done_clears", 32'(clr_cnt), 32'd2);
               done_cnt++;
               beat_idx = 0;
               clr_cnt  = 0;
               if (lat_q.size() == 0) fail("done_unexpected");
               else check("done_cycle", 32'(cyc - t0), 32'(lat_q.pop_front()));
            end
            busy_prev = busy;
            done_prev = done;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected traffic for one opening: reads b0 then b1, writes b1 (erode) then b0 (dilate).
   task automatic expect_frame(input int done_at);
      rd_t r;
      wr_t w;
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < N; a++) begin
            r.bank = p[0];
            r.addr = AW'(a);
            rd_q.push_back(r);
            w.sel  = p[0];
            w.bank = ~p[0];
            w.addr = AW'(a);
            wr_q.push_back(w);
         end
      end
      lat_q.push_back(done_at);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic check_reset_outs(input string nm);
      check(nm, 32'({busy, done, pass_sel, core_valid, core_rst_n,
                     mem_rd_en, mem_rd_bank, mem_wr_en, mem_wr_bank}), 32'b0_0001_0000);
      check({nm, "_addr"}, 32'({mem_rd_addr, mem_wr_addr}), 32'd0);
   endtask

   task automatic drain(input string nm);
      check({nm, "_rd_left"}, 32'(rd_q.size()), 32'd0);
      check({nm, "_wr_left"}, 32'(wr_q.size()), 32'd0);
      check({nm, "_done_left"}, 32'(lat_q.size()), 32'd0);
      check({nm, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      tick(2);
      check_reset_outs("reset_outs");
      rst_n = 1'b1;
      tick(2);

      // Plain run: done in cycle 34.
      expect_frame(34);
      pulse_start();
      tick(44);
      drain("plain");

      // Hold for 5 cycles right after issue 6 (issue 6 is in cycle 7).
      expect_frame(39);
      pulse_start();
      tick(8);
      hold = 1'b1;
      tick(5);
      hold = 1'b0;
      tick(40);
      drain("hold_mid");

      // Hold over erode flush beats (cycles 14-16), then over CLR_D and first DILATE cycles (20-22).
      expect_frame(39);
      pulse_start();
      tick(14);
      hold = 1'b1;
      tick(3);
      hold = 1'b0;
      tick(3);
      hold = 1'b1;
      tick(3);
      hold = 1'b0;
      tick(30);
      drain("hold_boundary");

      // start during ERODE (cycle 5) and in the DONE cycle (34) must both be ignored.
      expect_frame(34);
      pulse_start();
      tick(5);
      pulse_start();
      tick(28);
      pulse_start();
      tick(3);
      check("start_in_done_ignored", 32'(busy), 32'd0);
      tick(10);
      drain("start_ignored");

      // Reset mid-DILATE (cycle 25), then a clean frame.
      expect_frame(34);
      pulse_start();
      tick(25);
      rst_n = 1'b0;
      #1;
      check_reset_outs("abort_outs");
      rd_q.delete();
      wr_q.delete();
      lat_q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(2);
      expect_frame(34);
      pulse_start();
      tick(44);
      drain("after_abort");

      check("done_pulses", 32'(done_cnt), 32'd5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
